right_shifter_ctrl: RTL and testbench

//  Sequencer for the 16-bit right shift register (ld / shift_enable datapath).
//  It accepts a shift request and drives ld for one cycle to load the operand.
//  It then drives shift_enable cycle by cycle until the requested shift is complete.
//  Two modes: fixed shift amount, or normalise (shift until LSB=1 or register empty).

---
 rtl/right_shifter_ctrl.sv | 111 +++++++++++
 tb/tb_right_shifter_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/right_shifter_ctrl.sv
// right_shifter_ctrl: sequencer for a 16-bit right shift register.
// A request is accepted from IDLE, ld is pulsed for one cycle to load the
// operand, then shift_enable is driven cycle by cycle until the fixed amount
// is reached (mode 0) or the register is normalised (mode 1). A one-cycle
// done pulse ends every request; shift_count reports the shifts performed.
//
// Handshake: start is a request pulse that is taken only on a rising edge
// where ready=1. A start seen while ready=0 (including the DONE cycle) is
// dropped and does not disturb the captured mode or shift amount.
module right_shifter_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] shamt,
    input  logic             lsb_in,
    input  logic             zero_in,
    output logic             ld,
    output logic             shift_enable,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state;
    logic             mode_q;
    logic [CNT_W-1:0] shamt_q;
    logic             count_full;
    logic             stop;

    // Stop condition for the SHIFT state; shift_enable is Mealy so the
    // shifter stops on the same cycle its LSB or zero flag qualifies.
    always_comb begin
        count_full   = (shift_count == WIDTH_C);
        stop         = mode_q ? (lsb_in | zero_in | count_full)
                              : (shift_count == shamt_q);
        shift_enable = (state == S_SHIFT) && !stop;
    end

    assign state_dbg = state;

    // Request sequencer with registered ld/done/ready/busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            shamt_q     <= '0;
            shift_count <= '0;
            ld          <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        // Amounts beyond the register width are clamped so the
                        // counter can never run past WIDTH.
                        shamt_q     <= (shamt > WIDTH_C) ? WIDTH_C : shamt;
                        shift_count <= '0;
                        state       <= S_LOAD;
                        ld          <= 1'b1;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    ld    <= 1'b0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!stop) begin
                        shift_count <= shift_count + CNT_W'(1);
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ld    <= 1'b0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_shifter_ctrl.sv
// tb_right_shifter_ctrl: directed bench for right_shifter_ctrl with a
// behavioural 16-bit right shift register closing the lsb/zero loop.
module tb_right_shifter_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] shamt;
    logic             lsb_in;
    logic             zero_in;
    logic             ld;
    logic             shift_enable;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shift_count;
    logic [1:0]       state_dbg;

    logic [15:0]      operand;
    logic [15:0]      sh;

    int compared;
    int mismatched;

    right_shifter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .shamt        (shamt),
        .lsb_in       (lsb_in),
        .zero_in      (zero_in),
        .ld           (ld),
        .shift_enable (shift_enable),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .shift_count  (shift_count),
        .state_dbg    (state_dbg)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register model: load on ld, logical right shift on shift_enable.
    initial sh = 16'h0000;
    always @(posedge clk) begin
        if (ld) sh <= operand;
        else if (shift_enable) sh <= sh >> 1;
    end
    assign lsb_in  = sh[0];
    assign zero_in = (sh == 16'h0000);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request: start is sampled at edge 0; cycle c is the cycle after edge c-1.
    // inj > 0 pulses start (shamt=7, mode 0) at cycle inj to probe ignored starts.
    task automatic run_req(input string name, input logic m, input logic [CNT_W-1:0] amt,
                           input logic [15:0] op, input int inj,
                           input int exp_se_cnt, input int exp_se_first, input int exp_se_last,
                           input int exp_done_c, input int exp_count, input logic [15:0] exp_sh);
        int ld_cnt, ld_first, se_cnt, se_first, se_last, done_cnt, done_c, both, rdy_at_done;
        ld_cnt = 0; ld_first = 0; se_cnt = 0; se_first = 0; se_last = 0;
        done_cnt = 0; done_c = 0; both = 0; rdy_at_done = 1;
        @(negedge clk);
        mode = m; shamt = amt; operand = op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (ld) begin
                ld_cnt++;
                if (ld_first == 0) ld_first = c;
            end
            if (shift_enable) begin
                se_cnt++;
                if (se_first == 0) se_first = c;
                se_last = c;
            end
            if (ld && shift_enable) both++;
            if (done) begin
                done_cnt++;
                if (done_c == 0) begin
                    done_c = c;
                    rdy_at_done = int'(ready);
                    check({name, "_count_at_done"}, 32'(shift_count), 32'(exp_count));
                end
            end
            if (c == inj) begin
                start = 1'b1; shamt = 5'd7; mode = 1'b0;
            end
            if (done_c != 0 && c >= done_c + 4) break;
            @(posedge clk);
            #1 start = 1'b0;
        end
        check({name, "_ld_first"},  32'(ld_first), 32'd1);
        check({name, "_ld_count"},  32'(ld_cnt),   32'd1);
        check({name, "_se_count"},  32'(se_cnt),   32'(exp_se_cnt));
        check({name, "_se_first"},  32'(se_first), 32'(exp_se_first));
        check({name, "_se_last"},   32'(se_last),  32'(exp_se_last));
        check({name, "_done_cycle"}, 32'(done_c),  32'(exp_done_c));
        check({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check({name, "_ld_se_overlap"}, 32'(both), 32'd0);
        check({name, "_ready_at_done"}, 32'(rdy_at_done), 32'd0);
        check({name, "_ready_after"}, 32'(ready), 32'd1);
        check({name, "_count_held"}, 32'(shift_count), 32'(exp_count));
        check({name, "_shifter"}, 32'(sh), 32'(exp_sh));
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b0; start = 1'b0; mode = 1'b0; shamt = '0; operand = 16'h0000;

        // Reset state while rst is held low.
        #12;
        check("rst_ld",    32'(ld),           32'd0);
        check("rst_se",    32'(shift_enable), 32'd0);
        check("rst_done",  32'(done),         32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_ready", 32'(ready),        32'd1);
        check("rst_count", 32'(shift_count),  32'd0);
        check("rst_state", 32'(state_dbg),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fixed amount 3 on 0xA5A0; a start during DONE must be ignored.
        run_req("fixed3", 1'b0, 5'd3, 16'hA5A0, 6, 3, 2, 4, 6, 3, 16'h14B4);
        // Zero amount: load only.
        run_req("fixed0", 1'b0, 5'd0, 16'h1234, 0, 0, 0, 0, 3, 0, 16'h1234);
        // Clamp 20 down to 16.
        run_req("clamp", 1'b0, 5'd20, 16'hFFFF, 0, 16, 2, 17, 19, 16, 16'h0000);
        // Normalise 0x0008: three shifts.
        run_req("norm8", 1'b1, 5'd0, 16'h0008, 0, 3, 2, 4, 6, 3, 16'h0001);
        // Normalise zero operand: stops at once.
        run_req("norm0", 1'b1, 5'd0, 16'h0000, 0, 0, 0, 0, 3, 0, 16'h0000);
        // Normalise with LSB already set: stops at once.
        run_req("norm_lsb", 1'b1, 5'd9, 16'h0005, 0, 0, 0, 0, 3, 0, 16'h0005);
        // Start with shamt=7 while a shamt=2 request is shifting.
        run_req("busy_start", 1'b0, 5'd2, 16'h00F0, 2, 2, 2, 3, 5, 2, 16'h003C);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        mode = 1'b0; shamt = 5'd10; operand = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_se_before",   32'(shift_enable), 32'd1);
        check("mid_count_before", 32'(shift_count), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ld",    32'(ld),           32'd0);
        check("mid_rst_se",    32'(shift_enable), 32'd0);
        check("mid_rst_ready", 32'(ready),        32'd1);
        check("mid_rst_busy",  32'(busy),         32'd0);
        check("mid_rst_count", 32'(shift_count),  32'd0);
        check("mid_rst_state", 32'(state_dbg),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(state_dbg), 32'd0);

        // Normal operation resumes after the reset.
        run_req("after_rst", 1'b0, 5'd1, 16'h0003, 0, 1, 2, 2, 4, 1, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
